leaf_out_arbiter: RTL and testbench
===================================

Name: leaf_out_arbiter

Overview:
Round-robin arbiter that merges NUM_REQ user-kernel output streams onto a single leaf_interface user input port (din_leaf_user2interface / vld_user2interface / ack_interface2user).
- Sits inside a page, between user_kernel output ports and leaf_interface, so one leaf output port can be shared.
- Bounded bursts per grant ensure fairness; one registered output stage carries the payload plus the source requester id.

Parameters:
NUM_REQ, 4, number of requester streams (2..16)
PAYLOAD_BITS, 32, data width per stream
REQ_ID_BITS, 2, width of requester id; must equal clog2(NUM_REQ)
MAX_BURST, 8, max consecutive words accepted from one requester per grant (1..255)

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  asynchronous active-low reset
din_req  input  NUM_REQ*PAYLOAD_BITS  requester payloads, requester i at bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
vld_req  input  NUM_REQ  per-requester valid
ack_req  output  NUM_REQ  per-requester acknowledge
dout  output  PAYLOAD_BITS  payload to leaf_interface
dout_id  output  REQ_ID_BITS  requester index of dout
dout_vld  output  1  valid to leaf_interface
dout_ack  input  1  acknowledge from leaf_interface
busy  output  1  high when state is GRANT or the output register is full

Behaviour:
- Handshake: a transfer occurs on a rising edge where vld && ack are both high. A requester holds its data stable while vld is high and no ack has been received. The arbiter holds dout/dout_id/dout_vld stable until dout_ack.
- Reset (reset=0, async): state=IDLE, rr_ptr=0, gnt=0, burst_cnt=0, out_full=0. Outputs: ack_req=0, dout=0, dout_id=0, dout_vld=0, busy=0.
- Output register: out_full drives dout_vld.
  - can_load = !out_full || dout_ack.
  - On an input transfer, load dout <= din_req[gnt], dout_id <= gnt, out_full <= 1.
  - On dout_ack with no load, out_full <= 0.
  - Simultaneous dout_ack and load keeps out_full=1 with the new word, so full throughput is 1 word/cycle.
- ack_req[i] is combinational: ack_req[i] = (state==GRANT) && (gnt==i) && vld_req[i] && can_load. All other bits are 0.
- FSM IDLE:
  - If any vld_req bit is set, gnt <= first requester with vld set, searching from rr_ptr upward with wrap-around mod NUM_REQ.
  - Also burst_cnt <= 0 and go to GRANT.
  - No ack in IDLE. Arbitration latency: 1 cycle from vld to grant; first ack possible 1 cycle after vld rises.
- FSM GRANT:
  - Each transfer increments burst_cnt.
  - Go to IDLE with rr_ptr <= (gnt+1) mod NUM_REQ when either:
    - a transfer occurs with burst_cnt == MAX_BURST-1, or
    - vld_req[gnt] == 0.
  - If vld_req[gnt]=1 but can_load=0, stay in GRANT with no count change (stall).
- Latency: accepted word appears on dout_vld on the next cycle.
- Mid-operation reset clears everything immediately, including an unacknowledged output word, which is dropped.
- NUM_REQ not a power of two: rr_ptr wrap uses explicit compare with NUM_REQ-1, never natural overflow.
- No payload modification; dout_id is the only added information.

Optional Feature:
ARB_STATS_EN
- Defined: adds output stat_cnt (NUM_REQ*32), one 32-bit counter per requester. Each increments on that requester's transfer, wraps at 2^32-1 to 0, and clears on reset. Adds input stat_clr (1); stat_clr=1 zeroes all counters synchronously, and clear wins over a simultaneous increment.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Single requester, N=4, MAX_BURST=4: vld_req=4'b0001 held with data 1..10, dout_ack=1 -> grant 1 cycle after vld; words 1..10 appear in order with dout_id=0. Every 4th word is followed by a 1-cycle IDLE gap, then requester 0 is re-granted.
- Two contending requesters: vld_req=4'b0101 continuous, MAX_BURST=4 -> dout_id sequence 0,0,0,0,2,2,2,2,0,... with no word lost or duplicated.
- Backpressure: dout_ack=0 for 5 cycles with req1 valid -> exactly one word latched, ack_req=0 during stall, dout stable; ack released -> remaining words flow at 1/cycle.
- Round-robin wrap: N=3, rr_ptr=2 after a grant to req1, vld_req=3'b011 -> next grant goes to req0, not req1.
- Async reset asserted mid-burst with out_full=1 -> dout_vld, ack_req and busy drop to 0 immediately, without a clock edge. After release, arbitration restarts from rr_ptr=0.
- ARB_STATS_EN: 7 transfers from req3 then stat_clr pulse concurrent with an 8th transfer -> stat_cnt[3] reads 7, then 0 after the clear.

Source files
------------

// File: rtl/leaf_out_arbiter.sv
// Round-robin merge of NUM_REQ user-kernel output streams onto one leaf_interface input port.
// Optional per-requester transfer counters are built when ARB_STATS_EN is defined.
module leaf_out_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned REQ_ID_BITS  = 2,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
  input  logic [NUM_REQ-1:0]              vld_req,
  output logic [NUM_REQ-1:0]              ack_req,
  output logic [PAYLOAD_BITS-1:0]         dout,
  output logic [REQ_ID_BITS-1:0]          dout_id,
  output logic                            dout_vld,
  input  logic                            dout_ack,
  output logic                            busy
`ifdef ARB_STATS_EN
  ,
  input  logic                            stat_clr,
  output logic [NUM_REQ*32-1:0]           stat_cnt
`endif
);

  localparam int unsigned IW = REQ_ID_BITS + 1;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  state_e                  state_q;
  logic [REQ_ID_BITS-1:0]  gnt_q;
  logic [REQ_ID_BITS-1:0]  rr_ptr_q;
  logic [7:0]              burst_cnt_q;
  logic                    out_full_q;
  logic [PAYLOAD_BITS-1:0] dout_q;
  logic [REQ_ID_BITS-1:0]  dout_id_q;

  logic                    can_load;
  logic                    gnt_vld;
  logic                    xfer;
  logic                    burst_last;
  logic [PAYLOAD_BITS-1:0] gnt_data;
  logic [REQ_ID_BITS-1:0]  next_ptr;
  logic [REQ_ID_BITS-1:0]  pick;
  logic                    found;
  logic [IW-1:0]           idx;
  logic                    idx_vld;

  // Granted requester's valid and payload, selected by compare so no index is wider than needed.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q == REQ_ID_BITS'(i)) begin
        gnt_vld  = vld_req[i];
        gnt_data = din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  assign can_load   = !out_full_q || dout_ack;
  assign xfer       = (state_q == ST_GRANT) && gnt_vld && can_load;
  assign burst_last = (burst_cnt_q == 8'(MAX_BURST - 1));
  assign next_ptr   = (gnt_q == REQ_ID_BITS'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    ack_req = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ack_req[i] = xfer && (gnt_q == REQ_ID_BITS'(i));
    end
  end

  // First valid requester at or after rr_ptr; wrap is an explicit subtract so odd NUM_REQ works.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    idx     = '0;
    idx_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + IW'(k);
      if (idx >= IW'(NUM_REQ)) begin
        idx = idx - IW'(NUM_REQ);
      end
      idx_vld = 1'b0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (idx == IW'(j)) begin
          idx_vld = vld_req[j];
        end
      end
      if (!found && idx_vld) begin
        found = 1'b1;
        pick  = idx[REQ_ID_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            gnt_q       <= pick;
            burst_cnt_q <= '0;
            state_q     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!gnt_vld) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= next_ptr;
          end else if (can_load) begin
            burst_cnt_q <= burst_cnt_q + 8'd1;
            if (burst_last) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= next_ptr;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A load and a downstream ack in the same cycle keep the register full with the new word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_full_q <= 1'b0;
      dout_q     <= '0;
      dout_id_q  <= '0;
    end else if (xfer) begin
      out_full_q <= 1'b1;
      dout_q     <= gnt_data;
      dout_id_q  <= gnt_q;
    end else if (dout_ack) begin
      out_full_q <= 1'b0;
    end
  end

  assign dout     = dout_q;
  assign dout_id  = dout_id_q;
  assign dout_vld = out_full_q;
  assign busy     = (state_q == ST_GRANT) || out_full_q;

`ifdef ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] stat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (stat_clr) begin
          stat_q[i] <= '0;
        end else if (ack_req[i]) begin
          stat_q[i] <= stat_q[i] + 32'd1;
        end
      end
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: a 4-requester instance with MAX_BURST=4 and a
// 3-requester instance for round-robin wrap; counter checks follow ARB_STATS_EN.
module tb_leaf_out_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [127:0] din_req;
  logic [3:0]   vld_req;
  logic [3:0]   ack_req;
  logic [31:0]  dout;
  logic [1:0]   dout_id;
  logic         dout_vld;
  logic         dout_ack;
  logic         busy;

  logic [95:0]  din3;
  logic [2:0]   vld3;
  logic [2:0]   ack3;
  logic [31:0]  dout3;
  logic [1:0]   dout3_id;
  logic         dout3_vld;
  logic         dack3;
  logic         busy3;

`ifdef ARB_STATS_EN
  logic         stat_clr;
  logic [127:0] stat_cnt;
  logic [95:0]  stat_cnt3;
`endif

  leaf_out_arbiter #(.NUM_REQ(4), .PAYLOAD_BITS(32), .REQ_ID_BITS(2), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .din_req(din_req), .vld_req(vld_req), .ack_req(ack_req),
    .dout(dout), .dout_id(dout_id), .dout_vld(dout_vld), .dout_ack(dout_ack), .busy(busy)
`ifdef ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  leaf_out_arbiter #(.NUM_REQ(3), .PAYLOAD_BITS(32), .REQ_ID_BITS(2), .MAX_BURST(4)) u3 (
    .clk(clk), .reset(reset), .din_req(din3), .vld_req(vld3), .ack_req(ack3),
    .dout(dout3), .dout_id(dout3_id), .dout_vld(dout3_vld), .dout_ack(dack3), .busy(busy3)
`ifdef ARB_STATS_EN
    , .stat_clr(1'b0), .stat_cnt(stat_cnt3)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Requester model: requester i presents word 256*i + w[i] while w[i] <= last[i].
  int unsigned w[4];
  int unsigned last[4];
  logic        en[4];

  int e_ack[15] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  int e_dv[15]  = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0};
  int e_d[15]   = '{0, 0, 1, 2, 3, 4, 0, 5, 6, 7, 8, 0, 9, 10, 0};
  int t2_id[12] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
  int t2_d[12]  = '{1, 2, 3, 4, 'h201, 'h202, 'h203, 'h204, 5, 6, 7, 8};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      vld_req[i] = en[i] && (w[i] <= last[i]);
      din_req[i*32 +: 32] = 32'(256 * i) + 32'(w[i]);
    end
  endtask

  task automatic cycle();
    logic [3:0] a;
    #1;
    a = ack_req;
    @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      if (a[i]) w[i]++;
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0; w[i] = 1; last[i] = 0;
    end
    drive();
    cycle();
    cycle();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    logic done;
    reset    = 1'b0;
    dout_ack = 1'b1;
    din3     = '0;
    vld3     = '0;
    dack3    = 1'b1;
`ifdef ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0; w[i] = 1; last[i] = 0;
    end
    drive();
    #3;
    chk("rst_dout", dout, 0);
    chk("rst_dout_id", dout_id, 0);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack_req, 0);
    cycle();
    cycle();
    reset = 1'b1;
    #1;

    // Single requester, words 1..10 with a one-cycle IDLE gap after every 4th word
    en[0] = 1'b1; last[0] = 10;
    drive();
    #1;
    for (int c = 0; c < 15; c++) begin
      chk($sformatf("t1_ack_c%0d", c), ack_req, 64'(e_ack[c]));
      chk($sformatf("t1_vld_c%0d", c), dout_vld, 64'(e_dv[c]));
      if (e_dv[c] != 0) begin
        chk($sformatf("t1_dout_c%0d", c), dout, 64'(e_d[c]));
        chk($sformatf("t1_id_c%0d", c), dout_id, 0);
      end
      cycle();
    end

    // Two contending requesters 0 and 2
    do_reset();
    en[0] = 1'b1; last[0] = 100;
    en[2] = 1'b1; last[2] = 100;
    drive();
    #1;
    got = 0;
    for (int c = 0; c < 40 && got < 12; c++) begin
      if (dout_vld) begin
        chk($sformatf("t2_id_%0d", got), dout_id, 64'(t2_id[got]));
        chk($sformatf("t2_data_%0d", got), dout, 64'(t2_d[got]));
        got++;
      end
      cycle();
    end
    chk("t2_word_count", 64'(got), 12);
    en[0] = 1'b0; en[2] = 1'b0;
    drive();
    for (int c = 0; c < 4; c++) cycle();

    // Backpressure on requester 1
    dout_ack = 1'b0;
    en[1] = 1'b1; last[1] = 10;
    drive();
    #1;
    chk("t3_ack_idle", ack_req, 0);
    cycle();
    chk("t3_ack_first", ack_req, 4'b0010);
    chk("t3_vld_empty", dout_vld, 0);
    cycle();
    for (int c = 2; c < 6; c++) begin
      chk($sformatf("t3_stall_ack_c%0d", c), ack_req, 0);
      chk($sformatf("t3_stall_dout_c%0d", c), dout, 'h101);
      chk($sformatf("t3_stall_vld_c%0d", c), dout_vld, 1);
      chk($sformatf("t3_stall_busy_c%0d", c), busy, 1);
      cycle();
    end
    dout_ack = 1'b1;
    #1;
    chk("t3_release_ack", ack_req, 4'b0010);
    chk("t3_release_dout", dout, 'h101);
    cycle();
    chk("t3_flow_dout2", dout, 'h102);
    chk("t3_flow_ack2", ack_req, 4'b0010);
    cycle();
    chk("t3_flow_dout3", dout, 'h103);
    chk("t3_flow_ack3", ack_req, 4'b0010);
    cycle();
    chk("t3_flow_dout4", dout, 'h104);
    chk("t3_burst_end_ack", ack_req, 0);
    en[1] = 1'b0;
    drive();
    for (int c = 0; c < 4; c++) cycle();

    // Async reset mid-burst while the output register holds a word
    en[2] = 1'b1; last[2] = 100;
    drive();
    #1;
    chk("t5_ack_idle", ack_req, 0);
    cycle();
    chk("t5_ack_req2", ack_req, 4'b0100);
    cycle();
    chk("t5_pre_vld", dout_vld, 1);
    chk("t5_pre_id", dout_id, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_vld", dout_vld, 0);
    chk("t5_rst_ack", ack_req, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_dout", dout, 0);
    en[1] = 1'b1; last[1] = 100;
    drive();
    cycle();
    reset = 1'b1;
    #1;
    chk("t5_after_idle_ack", ack_req, 0);
    cycle();
    chk("t5_after_grant", ack_req, 4'b0010);
    cycle();
    chk("t5_after_id", dout_id, 1);
    chk("t5_after_vld", dout_vld, 1);
    en[1] = 1'b0; en[2] = 1'b0;
    drive();
    for (int c = 0; c < 4; c++) cycle();

    // Three requesters: rr_ptr wraps from 2 back to 0
    vld3 = 3'b010;
    din3[63:32] = 32'h55;
    #1;
    chk("t4_ack_idle", ack3, 0);
    cycle();
    chk("t4_ack_req1", ack3, 3'b010);
    cycle();
    vld3 = 3'b000;
    #1;
    chk("t4_dout_id1", dout3_id, 1);
    chk("t4_dout1", dout3, 'h55);
    chk("t4_vld1", dout3_vld, 1);
    cycle();
    vld3 = 3'b011;
    din3[31:0] = 32'h33;
    #1;
    chk("t4_ack_idle2", ack3, 0);
    cycle();
    chk("t4_ack_wrap", ack3, 3'b001);
    cycle();
    vld3 = 3'b000;
    #1;
    chk("t4_dout_wrap", dout3, 'h33);
    chk("t4_id_wrap", dout3_id, 0);
    cycle();

`ifdef ARB_STATS_EN
    do_reset();
    en[3] = 1'b1; last[3] = 8;
    drive();
    #1;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (ack_req[3] && w[3] == 8) begin
        chk("stat_before_clr", stat_cnt[127:96], 7);
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        #1;
        chk("stat_after_clr", stat_cnt[127:96], 0);
        done = 1'b1;
      end else begin
        cycle();
      end
    end
    chk("stat_eighth_seen", done, 1);
`else
    done = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
